wb: RTL
=======

WB -- requirements
Module: wb

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port in_valid  in  1  upstream (MEM stage) presents a retiring instruction.
REQ-004 SHALL have port in_ready  out  1  block can accept an entry this cycle.
REQ-005 SHALL have port wd3_selector  in  1  0 = write ALU result, 1 = write formatted load data.
REQ-006 SHALL have ports we3 (in 1), wa3 (in 5), funct3 (in 3): write enable, destination register, load width/sign code.
REQ-007 SHALL have ports alu_result (in 32) and mem_rdata (in 32): ALU result/load address, and raw aligned memory word.
REQ-008 SHALL have port freeze  in  1  debug halt; blocks commits while high.
REQ-009 SHALL have ports we3_out (out 1), wa3_out (out 5), wd3_out (out 32), driving the register-file write port in the decode stage.
REQ-010 SHALL have port instret  out  64  retired-instruction count.

Function
REQ-011 SHALL contain a 2-entry FIFO of {we3, wa3, wd3}; count in 0..2; in_ready = (count != 2).
REQ-012 SHALL push when in_valid && in_ready; all pushed fields are sampled that edge; in_valid with in_ready low is ignored (no push).
REQ-013 SHALL compute wd3 at push: wd3_selector=0 -> alu_result; =1 -> load-formatted mem_rdata.
REQ-014 Load format SHALL use off = alu_result[1:0]: funct3 000 LB sign-extend byte[off]; 100 LBU zero-extend byte[off]; 001 LH sign-extend half[off[1]]; 101 LHU zero-extend half[off[1]]; 010 and all other codes -> full word; off[0] ignored for halves.
REQ-015 Commit (pop) SHALL occur in every cycle with count>0 and freeze=0; one entry per cycle max.
REQ-016 we3_out SHALL = commit && head.we3 && (head.wa3 != 0); x0 writes suppressed but still popped and retired.
REQ-017 wa3_out/wd3_out SHALL show head entry fields when count>0, else 0.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged; order strictly FIFO.
REQ-019 Zero-latency path: pushed entry SHALL be committable the cycle after push, never the same cycle.
REQ-020 freeze=1 SHALL hold FIFO contents and force we3_out=0; pushes continue until full.

Reset
REQ-021 reset=0 SHALL asynchronously clear count to 0, in_ready to 1, we3_out/wa3_out/wd3_out to 0, instret to 0.
REQ-022 Reset mid-operation SHALL discard buffered entries; no write issued during or on release.
REQ-023 First push SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-024 Macro WB_INSTRET_EN defined: instret SHALL increment by 1 on every pop (including x0 and we3=0 entries), wrapping 2^64-1 -> 0.
REQ-025 WB_INSTRET_EN undefined: instret SHALL be constant 0 and the counter SHALL not be built.

Verification
REQ-026 Push {we3=1,wa3=5,sel=0,alu=0x1234_5678} -> next cycle we3_out=1, wa3_out=5, wd3_out=0x1234_5678; instret=1 after.
REQ-027 Loads with mem_rdata=0x80FF_7F01: LB off=3 -> 0xFFFF_FF80; LBU off=1 -> 0x0000_007F; LH off=2 -> 0xFFFF_80FF; LHU off=0 -> 0x0000_7F01.
REQ-028 Push wa3=0,we3=1 -> we3_out stays 0, entry popped, instret increments.
REQ-029 freeze=1, three back-to-back in_valid -> in_ready drops after 2 pushes, third held; release freeze -> two commits in order on consecutive cycles, then third accepted.
REQ-030 Assert reset with 2 entries buffered -> outputs 0 immediately, in_ready=1, no write after release.
REQ-031 With WB_INSTRET_EN, force instret=0xFFFF_FFFF_FFFF_FFFF then one commit -> instret=0.

Source files
------------

// File: rtl/wb.sv
// -----------------------------------------------------------------------------
// wb -- write-back stage buffer.
//
// Holds up to two retiring instructions from the MEM stage as {we3, wa3, wd3}
// and commits the oldest one per cycle to the register-file write port in the
// decode stage. Load data is width/sign formatted at push time, so the buffer
// only stores final write data.
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-low reset
//   in_valid      in   upstream presents a retiring instruction
//   in_ready      out  buffer can accept an entry this cycle
//   wd3_selector  in   0 = ALU result, 1 = formatted load data
//   we3, wa3      in   write enable, destination register
//   funct3        in   load width/sign code
//   alu_result    in   ALU result / load address
//   mem_rdata     in   raw aligned memory word
//   freeze        in   debug halt, blocks commits while high
//   we3_out       out  register-file write enable
//   wa3_out       out  register-file write address (head entry, else 0)
//   wd3_out       out  register-file write data (head entry, else 0)
//   instret       out  retired-instruction count
//
// Configuration:
//   WB_INSTRET_EN  when defined, builds the 64-bit retired-instruction counter;
//                  otherwise instret is tied to 0.
// -----------------------------------------------------------------------------
module wb (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        wd3_selector,
    input  logic        we3,
    input  logic [4:0]  wa3,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        freeze,
    output logic        we3_out,
    output logic [4:0]  wa3_out,
    output logic [31:0] wd3_out,
    output logic [63:0] instret
);

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } entry_t;

    // Byte/half select and sign/zero extension of a load word.
    function automatic logic [31:0] load_fmt(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = $signed(word[8*off +: 8]);
        h = off[1] ? $signed(word[31:16]) : $signed(word[15:0]);
        case (f3)
            3'b000:  res = 32'(b);
            3'b100:  res = {24'd0, b};
            3'b001:  res = 32'(h);
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    entry_t     mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop, has_head;
    entry_t     head, new_entry;

    assign in_ready = (count_q != 2'd2);
    assign push     = in_valid && in_ready;
    assign has_head = (count_q != 2'd0);
    assign pop      = has_head && !freeze;

    always_comb begin
        new_entry.we = we3;
        new_entry.wa = wa3;
        new_entry.wd = wd3_selector ? load_fmt(funct3, alu_result[1:0], mem_rdata)
                                    : alu_result;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset: it is only observed when count_q says so.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    // Outputs come straight from the head so a pushed entry commits the next cycle.
    assign head     = mem_q[rd_ptr_q];
    assign we3_out  = pop && head.we && (head.wa != 5'd0);
    assign wa3_out  = has_head ? head.wa : 5'd0;
    assign wd3_out  = has_head ? head.wd : 32'd0;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   instret_q <= 64'd0;
        else if (pop) instret_q <= instret_q + 64'd1;
    end

    assign instret = instret_q;
`else
    assign instret = 64'd0;
`endif

endmodule
